// File: rtl/mul_result_buffer.sv
// ---------------------------------------------------------------------------
// mul_result_buffer: tracks multiplier issue tags and queues results in a
// credit-managed FIFO toward writeback.            Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mul_result_buffer #(
  parameter int WIDTH   = 32,
  parameter int TAG_W   = 5,
  parameter int LATENCY = 5,
  parameter int DEPTH   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic [WIDTH-1:0] mul_result,
  input  logic             mul_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_overflow,
  output logic [TAG_W-1:0] out_tag
);

  localparam int C_CNT_W = $clog2(DEPTH + 1);
  localparam int C_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [C_PTR_W-1:0] C_LAST_PTR = C_PTR_W'(DEPTH - 1);
  localparam logic [C_CNT_W:0]   C_DEPTH    = (C_CNT_W + 1)'(DEPTH);

  logic [LATENCY-1:0] r_pipe_v;
  logic [TAG_W-1:0]   r_pipe_tag [LATENCY];

  logic [WIDTH-1:0]   r_mem_result [DEPTH];
  logic               r_mem_ovf    [DEPTH];
  logic [TAG_W-1:0]   r_mem_tag    [DEPTH];

  logic [C_PTR_W-1:0] r_wr_ptr;
  logic [C_PTR_W-1:0] r_rd_ptr;
  logic [C_CNT_W-1:0] r_count;

  logic [C_CNT_W-1:0] w_inflight;
  logic               w_accept;
  logic               w_push;
  logic               w_pop;

  function automatic logic [C_PTR_W-1:0] f_next(input logic [C_PTR_W-1:0] p);
    return (p == C_LAST_PTR) ? '0 : p + C_PTR_W'(1);
  endfunction

  // Credit uses registered state only, so a same-cycle pop never frees a slot early.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      w_inflight = w_inflight + C_CNT_W'(r_pipe_v[i]);
    end
  end

  assign issue_ready = ({1'b0, w_inflight} + {1'b0, r_count}) < C_DEPTH;
  assign w_accept    = issue_valid && issue_ready;
  assign w_push      = r_pipe_v[LATENCY-1];
  assign w_pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe_v <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_pipe_tag[i] <= '0;
      end
    end else begin
      r_pipe_v      <= {r_pipe_v[LATENCY-2:0], w_accept};
      r_pipe_tag[0] <= w_accept ? issue_tag : '0;
      for (int i = 1; i < LATENCY; i++) begin
        r_pipe_tag[i] <= r_pipe_tag[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= f_next(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= f_next(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CNT_W'(1);
        2'b01:   r_count <= r_count - C_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the head is gated by out_valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_result[r_wr_ptr] <= mul_result;
      r_mem_ovf[r_wr_ptr]    <= mul_overflow;
      r_mem_tag[r_wr_ptr]    <= r_pipe_tag[LATENCY-1];
    end
  end

  assign out_valid    = (r_count != '0);
  assign out_result   = out_valid ? r_mem_result[r_rd_ptr] : '0;
  assign out_overflow = out_valid ? r_mem_ovf[r_rd_ptr]    : 1'b0;
  assign out_tag      = out_valid ? r_mem_tag[r_rd_ptr]    : '0;

endmodule

`default_nettype wire
